// File: rtl/led_pattern_engine.sv
// LED pattern sequencer: a programmable divider paces FILL, CHASE, BOUNCE and
// BLINK patterns across WIDTH outputs, with step and cycle-complete pulses.
module led_pattern_engine #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 25_000_000
) (
  input  logic             clk_50M,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  output logic [WIDTH-1:0] out,
  output logic             step,
  output logic             cycle_done
);

  localparam int unsigned   CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    CHASE  = 2'd1,
    BOUNCE = 2'd2,
    BLINK  = 2'd3
  } mode_t;

  // FWD = FILL "on" / BOUNCE "up"; REV = FILL "off" / BOUNCE "down"
  typedef enum logic {
    PH_FWD = 1'b0,
    PH_REV = 1'b1
  } phase_t;

  logic [CW-1:0]    cnt;
  mode_t            mode_q;
  logic             dir_q;
  phase_t           phase;

  mode_t            mode_in;
  logic             tick;
  logic             restart;
  logic [WIDTH-1:0] lsb_bit;
  logic [WIDTH-1:0] msb_bit;
  logic [WIDTH-1:0] start_pat;
  logic [WIDTH-1:0] home;
  logic [WIDTH-1:0] far_end;
  logic [WIDTH-1:0] nxt_out;
  logic             nxt_done;
  phase_t           nxt_phase;

  assign mode_in = mode_t'(mode);
  assign tick    = en && (cnt == CNT_LAST);
  assign lsb_bit = WIDTH'(1);
  assign msb_bit = {1'b1, {(WIDTH-1){1'b0}}};
  assign home    = dir_q ? msb_bit : lsb_bit;
  assign far_end = dir_q ? lsb_bit : msb_bit;

  // BLINK ignores direction, so a dir change alone never restarts it
  assign restart = (mode_in != mode_q) || ((dir != dir_q) && (mode_q != BLINK));

  always_comb begin
    start_pat = '0;
    case (mode_in)
      FILL:   start_pat = '0;
      CHASE:  start_pat = dir ? msb_bit : lsb_bit;
      BOUNCE: start_pat = dir ? msb_bit : lsb_bit;
      BLINK:  start_pat = '1;
    endcase
  end

  always_comb begin
    nxt_out   = start_pat;
    nxt_done  = 1'b0;
    nxt_phase = PH_FWD;
    if (!restart) begin
      case (mode_q)
        FILL: begin
          if (phase == PH_FWD) begin
            nxt_out   = dir_q ? {1'b1, out[WIDTH-1:1]} : {out[WIDTH-2:0], 1'b1};
            nxt_phase = (nxt_out == '1) ? PH_REV : PH_FWD;
          end else begin
            nxt_out = dir_q ? {1'b0, out[WIDTH-1:1]} : {out[WIDTH-2:0], 1'b0};
            if (nxt_out == '0) begin
              nxt_phase = PH_FWD;
              nxt_done  = 1'b1;
            end else begin
              nxt_phase = PH_REV;
            end
          end
        end
        CHASE: begin
          if (out == '0) begin
            nxt_out = home;
          end else begin
            nxt_out  = dir_q ? {out[0], out[WIDTH-1:1]} : {out[WIDTH-2:0], out[WIDTH-1]};
            nxt_done = (nxt_out == home);
          end
        end
        BOUNCE: begin
          if (out == '0) begin
            nxt_out = home;
          end else if (phase == PH_FWD) begin
            nxt_out   = dir_q ? (out >> 1) : (out << 1);
            nxt_phase = (nxt_out == far_end) ? PH_REV : PH_FWD;
          end else begin
            nxt_out = dir_q ? (out << 1) : (out >> 1);
            if (nxt_out == home) begin
              nxt_phase = PH_FWD;
              nxt_done  = 1'b1;
            end else begin
              nxt_phase = PH_REV;
            end
          end
        end
        BLINK: begin
          nxt_out  = (out == '1) ? '0 : '1;
          nxt_done = (out == '1);
        end
      endcase
    end
  end

  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      out        <= '0;
      step       <= 1'b0;
      cycle_done <= 1'b0;
      mode_q     <= FILL;
      dir_q      <= 1'b0;
      phase      <= PH_FWD;
    end else begin
      step       <= 1'b0;
      cycle_done <= 1'b0;
      if (tick) begin
        cnt        <= '0;
        out        <= nxt_out;
        step       <= 1'b1;
        cycle_done <= nxt_done;
        phase      <= nxt_phase;
        mode_q     <= mode_in;
        dir_q      <= dir;
      end else if (en) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Scoreboard bench: two engines (DIV=3 and DIV=1, WIDTH=4) share one stimulus
// stream; a sequence-table model predicts every edge and every step.
module tb_led_pattern_engine;

  localparam int W = 4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       dir;

  logic [W-1:0] out3, out1;
  logic         step3, step1;
  logic         done3, done1;

  led_pattern_engine #(.WIDTH(W), .DIV(3)) dut3 (
    .clk_50M(clk), .reset(rst_n), .en(en), .mode(mode), .dir(dir),
    .out(out3), .step(step3), .cycle_done(done3)
  );

  led_pattern_engine #(.WIDTH(W), .DIV(1)) dut1 (
    .clk_50M(clk), .reset(rst_n), .en(en), .mode(mode), .dir(dir),
    .out(out1), .step(step1), .cycle_done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  logic mon_on   = 1'b0;

  // timing entries {rst_seen, step}; data entries {cycle_done, out}
  logic [1:0] tq0[$], tq1[$];
  logic [4:0] dq0[$], dq1[$];

  int         en_cnt[2];
  int         idx[2];
  int         mode_m[2];
  int         dir_m[2];
  logic       pend_rst[2];
  logic [W-1:0] last_out[2];

  function automatic logic [W-1:0] mirror(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  function automatic int seq_len(input int m);
    case (m)
      0: return 2 * W;
      1: return W;
      2: return 2 * W - 2;
      default: return 2;
    endcase
  endfunction

  function automatic int done_pos(input int m);
    return (m == 3) ? 1 : 0;
  endfunction

  // k-th pattern of the periodic sequence, index 0 is the start pattern
  function automatic logic [W-1:0] pat(input int m, input int d, input int k);
    int full;
    int pos;
    logic [W-1:0] p;
    full = (1 << W) - 1;
    case (m)
      0: p = (k <= W) ? W'((1 << k) - 1) : W'(full & ~((1 << (k - W)) - 1));
      1: p = W'(1 << k);
      2: begin
        pos = (k < W) ? k : (2 * W - 2 - k);
        p = W'(1 << pos);
      end
      default: p = (k == 0) ? W'(full) : '0;
    endcase
    if (d != 0 && m != 3) p = mirror(p);
    return p;
  endfunction

  task automatic reset_unit(input int u);
    en_cnt[u] = 0;
    idx[u]    = 0;
    mode_m[u] = 0;
    dir_m[u]  = 0;
  endtask

  task automatic push_t(input int u, input logic [1:0] e);
    if (u == 0) tq0.push_back(e); else tq1.push_back(e);
  endtask

  task automatic push_d(input int u, input logic [4:0] e);
    if (u == 0) dq0.push_back(e); else dq1.push_back(e);
  endtask

  // predicts the outcome of the coming rising edge for the inputs now applied
  task automatic model_edge(input int u, input int divv);
    logic st;
    logic cd;
    logic rs;
    int   md;
    int   dr;
    st = 1'b0;
    cd = 1'b0;
    md = int'(mode);
    dr = int'(dir);
    if (!rst_n) begin
      reset_unit(u);
      pend_rst[u] = 1'b0;
      push_t(u, 2'b10);
    end else begin
      if (en) begin
        en_cnt[u]++;
        if (en_cnt[u] == divv) begin
          en_cnt[u] = 0;
          st = 1'b1;
          rs = (md != mode_m[u]) || (dr != dir_m[u] && mode_m[u] != 3);
          if (rs) begin
            idx[u] = 0;
            cd = 1'b0;
          end else begin
            idx[u] = (idx[u] + 1) % seq_len(mode_m[u]);
            cd = (idx[u] == done_pos(mode_m[u]));
          end
          mode_m[u] = md;
          dir_m[u]  = dr;
          push_d(u, {cd, pat(md, dr, idx[u])});
        end
      end
      push_t(u, {pend_rst[u], st});
      pend_rst[u] = 1'b0;
    end
  endtask

  task automatic check_unit(input int u, input logic st, input logic [W-1:0] o, input logic cd);
    logic [1:0] te;
    logic [4:0] de;
    if ((u == 0 ? tq0.size() : tq1.size()) == 0) begin
      vectors++; miscompares++;
      $display("FAIL timing_underflow u%0d t=%0t", u, $time);
      return;
    end
    te = (u == 0) ? tq0.pop_front() : tq1.pop_front();
    if (te[1]) last_out[u] = '0;
    vectors++;
    if (st !== te[0]) begin
      miscompares++;
      $display("FAIL step u%0d t=%0t got %b want %b", u, $time, st, te[0]);
    end
    if (st) begin
      if ((u == 0 ? dq0.size() : dq1.size()) == 0) begin
        vectors++; miscompares++;
        $display("FAIL data_underflow u%0d t=%0t", u, $time);
      end else begin
        de = (u == 0) ? dq0.pop_front() : dq1.pop_front();
        vectors++;
        if (o !== de[W-1:0] || cd !== de[4]) begin
          miscompares++;
          $display("FAIL step_data u%0d t=%0t got out=%b cd=%b want out=%b cd=%b",
                   u, $time, o, cd, de[W-1:0], de[4]);
        end
        last_out[u] = de[W-1:0];
      end
    end else begin
      vectors++;
      if (o !== last_out[u] || cd !== 1'b0) begin
        miscompares++;
        $display("FAIL hold u%0d t=%0t got out=%b cd=%b want out=%b cd=0",
                 u, $time, o, cd, last_out[u]);
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_on) begin
      check_unit(0, step3, out3, done3);
      check_unit(1, step1, out1, done1);
    end
  end

  task automatic immediate_reset_check();
    vectors++;
    if (out3 !== '0 || step3 !== 1'b0 || done3 !== 1'b0 ||
        out1 !== '0 || step1 !== 1'b0 || done1 !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset t=%0t got out3=%b st3=%b cd3=%b out1=%b st1=%b cd1=%b want all zero",
               $time, out3, step3, done3, out1, step1, done1);
    end
  endtask

  task automatic cycle(input logic rn, input logic e, input logic [1:0] md,
                       input logic dr, input logic pulse);
    @(negedge clk);
    rst_n = rn;
    en    = e;
    mode  = md;
    dir   = dr;
    if (pulse && rn) begin
      #2 rst_n = 1'b0;
      #1 immediate_reset_check();
      #1 rst_n = 1'b1;
      for (int u = 0; u < 2; u++) begin
        reset_unit(u);
        pend_rst[u] = 1'b1;
      end
    end
    model_edge(0, 3);
    model_edge(1, 1);
    mon_on = 1'b1;
  endtask

  task automatic run(input int n, input logic e, input logic [1:0] md, input logic dr);
    for (int i = 0; i < n; i++) cycle(1'b1, e, md, dr, 1'b0);
  endtask

  initial begin
    logic       r_en;
    logic [1:0] r_mode;
    logic       r_dir;
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 2'd0;
    dir   = 1'b0;
    for (int u = 0; u < 2; u++) begin
      reset_unit(u);
      pend_rst[u] = 1'b0;
      last_out[u] = '0;
    end

    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    run(30, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    run(30, 1'b1, 2'd2, 1'b0);
    run(10, 1'b1, 2'd1, 1'b0);
    run(10, 1'b0, 2'd1, 1'b0);
    run(10, 1'b1, 2'd1, 1'b0);
    run(14, 1'b1, 2'd3, 1'b0);
    run(11, 1'b1, 2'd0, 1'b0);
    cycle(1'b1, 1'b1, 2'd0, 1'b0, 1'b1);
    run(20, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 2'd1, 1'b1, 1'b0);
    run(12, 1'b1, 2'd1, 1'b1);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 2'd3, 1'(i % 2), 1'b0);
    run(20, 1'b1, 2'd2, 1'b1);

    r_en = 1'b1; r_mode = 2'd0; r_dir = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      r_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) r_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) r_dir = ~r_dir;
      if ($urandom_range(0, 199) == 0)
        cycle(1'b0, r_en, r_mode, r_dir, 1'b0);
      else
        cycle(1'b1, r_en, r_mode, r_dir, ($urandom_range(0, 149) == 0));
    end

    @(posedge clk);
    #3;
    vectors++;
    if (tq0.size() != 0 || tq1.size() != 0 || dq0.size() != 0 || dq1.size() != 0) begin
      miscompares++;
      $display("FAIL drain got tq0=%0d tq1=%0d dq0=%0d dq1=%0d want all 0",
               tq0.size(), tq1.size(), dq0.size(), dq1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
